// File: rtl/loader_pkg.sv
// Shared types for the byte-serial instruction loader: FSM states, marker defaults, byte index.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] START_BYTE_DEF = 8'hFE;
  localparam logic [7:0] END_BYTE_DEF   = 8'hFF;

  typedef logic [1:0] byte_idx_t;

endpackage

// File: rtl/byte_packer.sv
// Packs four bytes little-endian into a 32-bit word; word_valid_o pulses one cycle after byte 3.
// No backpressure: every valid byte is consumed on the edge it is sampled.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output byte_idx_t   idx_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  byte_idx_t   idx_q;
  logic [23:0] acc_q;
  logic [31:0] word_q;
  logic        vld_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      idx_q  <= '0;
      acc_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (valid_i) begin
        idx_q <= idx_q + 2'd1;
        case (idx_q)
          2'd0: acc_q[7:0]   <= data_i;
          2'd1: acc_q[15:8]  <= data_i;
          2'd2: acc_q[23:16] <= data_i;
          default: begin
            word_q <= {data_i, acc_q};
            vld_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign idx_o        = idx_q;
  assign word_o       = word_q;
  assign word_valid_o = vld_q;

endmodule

// File: rtl/instr_loader.sv
// Frames a byte stream into instruction-memory writes, one registered strobe per packed word.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined; no input backpressure.
module instr_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W     = 6,
  parameter logic [7:0] START_BYTE = START_BYTE_DEF,
  parameter logic [7:0] END_BYTE   = END_BYTE_DEF
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              busy_o,
  output logic              load_done_o,
  output logic              cpu_start_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              overflow_o,
  output logic              chk_err_o
);

  localparam int unsigned     DEPTH_I = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];

  state_e state_q, state_d;

  logic        pk_vld, pk_clr, pk_word_vld, is_end;
  byte_idx_t   pk_idx;
  logic [31:0] pk_word;

  logic              we_q, busy_q, done_q, start_q, ovf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [ADDR_W:0]   wr_cnt_q;

  byte_packer u_packer (
    .clk_i        (clk_i),
    .reset_i      (reset),
    .clear_i      (pk_clr),
    .valid_i      (pk_vld),
    .data_i       (instr_i),
    .idx_o        (pk_idx),
    .word_o       (pk_word),
    .word_valid_o (pk_word_vld)
  );

  // Markers only count at a word boundary; mid-word FE/FF are opcode data.
  assign is_end = (pk_idx == 2'd0) && (instr_i == END_BYTE);

  always_ff @(posedge clk_i) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pk_vld  = 1'b0;
    pk_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_i == START_BYTE) begin
          state_d = ST_LOAD;
          pk_clr  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (is_end) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          pk_vld = 1'b1;
        end
      end
      ST_CHK:  state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= (state_q == ST_LOAD) || (state_q == ST_CHK);
      if (pk_clr) wr_cnt_q <= '0;
      // A full memory drops further words instead of wrapping onto address 0.
      if (pk_word_vld) begin
        if (wr_cnt_q == DEPTH) begin
          ovf_q <= 1'b1;
        end else begin
          we_q     <= 1'b1;
          addr_q   <= wr_cnt_q[ADDR_W-1:0];
          data_q   <= pk_word;
          wr_cnt_q <= wr_cnt_q + (ADDR_W+1)'(1);
        end
      end
      if ((state_q == ST_DONE) && !done_q) begin
        done_q  <= 1'b1;
        start_q <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       chk_err_q;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (pk_clr)      xor_q <= '0;
      else if (pk_vld) xor_q <= xor_q ^ instr_i;
      if ((state_q == ST_CHK) && (instr_i != xor_q)) chk_err_q <= 1'b1;
    end
  end

  assign chk_err_o = chk_err_q;
`else
  assign chk_err_o = 1'b0;
`endif

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_data_o  = data_q;
  assign busy_o       = busy_q;
  assign load_done_o  = done_q;
  assign cpu_start_o  = start_q;
  assign word_count_o = wr_cnt_q;
  assign overflow_o   = ovf_q;

endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-serial instruction loader sitting directly upstream of the CPU core's instruction memory. It consumes the 8-bit `instr_i` stream driven by the bench or host, one byte per clock. It frames the stream with start/end markers, packs every four bytes into a little-endian 32-bit RISC-V word and writes it to consecutive instruction-memory addresses. When the program is complete it releases the core with a one-cycle start pulse.

## Interface
- `ADDR_W`, 6: instruction-memory word-address width. Depth is 2^ADDR_W words (64).
- `START_BYTE`, 8'hFE: start-of-program marker.
- `END_BYTE`, 8'hFF: end-of-program marker.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_i` in 8: byte stream, sampled every rising edge.
- `imem_we_o` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr_o` out ADDR_W: word address of the current write.
- `imem_data_o` out 32: word being written.
- `busy_o` out 1: high while in LOAD (and CHK).
- `load_done_o` out 1: sticky, high once loading is complete.
- `cpu_start_o` out 1: one-cycle pulse coincident with the rising edge of `load_done_o`.
- `word_count_o` out ADDR_W+1: number of words actually written.
- `overflow_o` out 1: sticky, set when the program exceeds the memory depth.
- `chk_err_o` out 1: sticky checksum mismatch. Tied 0 when the checksum is not compiled in.

## Operation
States: IDLE, LOAD, CHK (present only with the macro), DONE.

- **IDLE**
  - Every byte except `START_BYTE` is ignored.
  - `START_BYTE` moves the FSM to LOAD and clears the byte index, word address and running XOR.
- **LOAD**
  - A 2-bit byte index counts 0..3.
  - Byte k is placed at bits [8k+7:8k]; the first byte lands in [7:0].
  - When byte index 3 is sampled, the word is written at the current address, the address increments and the index returns to 0.
  - Markers are recognised only at byte index 0. RV32 opcodes never have a low byte of 0xFE or 0xFF, so at index 1..3 both values are ordinary data.
  - `END_BYTE` at index 0 moves the FSM to DONE, or to CHK when the checksum is enabled.
  - `START_BYTE` at index 0 inside LOAD is treated as data.
- **Overflow**
  - Once 2^ADDR_W words have been written, any further completed word raises `overflow_o`.
  - That word is not written (`imem_we_o` stays 0) and the address does not wrap.
  - `word_count_o` saturates at 2^ADDR_W.
  - Loading continues until the end marker.
- **DONE**
  - All input is ignored until `reset`.
  - `load_done_o` stays high.
- **Reset mid-operation**
  - The FSM returns to IDLE and all counters and sticky flags clear.
  - A partially assembled word is discarded and never written.
- **Reset values**
  - Every output resets to 0, including `imem_addr_o` and `imem_data_o`.

## Timing
- All outputs are registered.
- Byte 3 of a word is sampled at edge N. At edge N+1 the loader registers `imem_we_o`=1 together with `imem_addr_o` and `imem_data_o`, so all three are high/valid during cycle N+1 (one cycle of latency).
- `imem_we_o` is high for exactly one cycle per word. Back-to-back words give strobes four cycles apart.
- `word_count_o` updates at the same edge as the strobe.
- The end marker is sampled at edge E:
  - without the checksum, `load_done_o` rises and `cpu_start_o` pulses at edge E+1;
  - with the checksum, the checksum byte is sampled at E+1 and done/start follow at E+2.
- `cpu_start_o` lasts exactly one cycle.
- `busy_o` is high from the edge after the start marker until the edge on which `load_done_o` rises.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The single byte after `END_BYTE` is a checksum: the XOR of all data bytes received in LOAD, including bytes of discarded overflow words.
  - A mismatch sets `chk_err_o`. `load_done_o` and `cpu_start_o` still assert.
- `LOADER_CHECKSUM_EN` undefined:
  - The CHK state and the XOR register are absent and `chk_err_o` is constant 0.
  - Done is asserted directly after `END_BYTE`.

## Structure
- Package `loader_pkg`:
  - state enum (IDLE/LOAD/CHK/DONE);
  - `START_BYTE`/`END_BYTE` default constants;
  - byte-index type.
- Sub-module `byte_packer`:
  - shift/assemble register, 2-bit index and word-complete flag;
  - inputs: byte, valid, clear;
  - outputs: 32-bit word and a one-cycle `word_valid`.
- The top level holds the FSM, address/count, overflow logic and checksum.

## Test plan
- Stream FE,13,05,10,00,FF → one strobe: addr 0, data 0x00100513. `word_count_o`=1, `load_done_o`=1, single `cpu_start_o` pulse.
- Stream 00,00,FE, then two words, then FF → the leading zeros are ignored, writes go to addr 0 and 1, and done is asserted.
- Word containing data byte FF at index 2 (FE,13,05,FF,00,FF) → data 0x00FF0513 is written and loading ends only on the second FF.
- Load 65 words → 64 strobes, `overflow_o`=1, `word_count_o`=64, no write to address 0 after wrap.
- Assert `reset` after 2 bytes of the 3rd word → no third strobe, all outputs 0. A fresh load then starts at addr 0.
- With `LOADER_CHECKSUM_EN`, word 0x00100513 is followed by FF then 0x06 → `chk_err_o`=0. Repeating with checksum 0x07 → `chk_err_o`=1, done still asserted.
